// File: rtl/softmax_ru_ctrl.sv
// Log-domain softmax sequencer for a shared log2/pow2 reduction unit (RU).
// Loads N Q4.12 scores, computes exp(x-max) and their sum, then streams normalised probabilities.
module softmax_ru_ctrl #(
  parameter int N     = 8,
  parameter int ACC_W = 16 + $clog2(N)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] ru_in_0,
  output logic [15:0] ru_in_1,
  output logic        ru_sel_mult,
  output logic        ru_sel_mux,
  input  logic [15:0] ru_out_0,
  input  logic [15:0] ru_out_1
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_LOAD, S_PASS1, S_PASS2} state_t;

  state_t             state, state_nx;
  logic [IW-1:0]      idx;
  logic signed [15:0] mx;
  logic [ACC_W-1:0]   acc;
  logic [15:0]        vbuf [N];
  logic [15:0]        sum_sat;
  logic               idx_last, in_fire, out_fire;

  assign idx_last = (idx == IW'(N-1));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // RU only sees a 16-bit divisor; clamp the sum just below 8.0
  assign sum_sat  = (acc > ACC_W'(16'h7FFF)) ? 16'h7FFF : acc[15:0];

  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 16'h0000;
    out_last    = 1'b0;
    busy        = 1'b0;
    ru_in_0     = 16'h0000;
    ru_in_1     = 16'h0000;
    ru_sel_mult = 1'b0;
    ru_sel_mux  = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_fire && idx_last) state_nx = S_PASS1;
      end
      S_PASS1: begin
        busy        = 1'b1;
        ru_sel_mult = 1'b1;
        ru_sel_mux  = 1'b1;
        ru_in_0     = mx;
        ru_in_1     = vbuf[idx];
        if (idx_last) state_nx = S_PASS2;
      end
      S_PASS2: begin
        busy      = 1'b1;
        ru_in_0   = sum_sat;
        ru_in_1   = vbuf[idx];
        out_valid = 1'b1;
        out_data  = ru_out_1;
        out_last  = idx_last;
        if (out_fire && idx_last) state_nx = S_LOAD;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
      idx   <= '0;
      mx    <= 16'sh8000;
      acc   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_LOAD: if (in_fire) begin
          if ($signed(in_data) > mx) mx <= $signed(in_data);
          idx <= idx_last ? '0 : idx + IW'(1);
          if (idx_last) acc <= '0;
        end
        S_PASS1: begin
          acc <= acc + ACC_W'(ru_out_1);
          idx <= idx_last ? '0 : idx + IW'(1);
        end
        S_PASS2: if (out_fire) begin
          idx <= idx_last ? '0 : idx + IW'(1);
          if (idx_last) mx <= 16'sh8000;
        end
        default: ;
      endcase
    end
  end

  // Scores are overwritten in place by their shifted exponents during pass 1
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_LOAD && in_fire) vbuf[idx] <= in_data;
      else if (state == S_PASS1)      vbuf[idx] <= ru_out_0;
    end
  end
endmodule

// File: tb/tb_softmax_ru_ctrl.sv
// Bench for softmax_ru_ctrl with a behavioural RU beside the DUT and a vector-level softmax model.
module tb_softmax_ru_ctrl;
  localparam int N = 8;
  typedef logic [N-1:0][15:0] vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, busy;
  logic [15:0] in_data = 16'h0, out_data, ru_in_0, ru_in_1, ru_out_0, ru_out_1;
  logic ru_sel_mult, ru_sel_mux;
  int total = 0, bad = 0;
  bit rdy_mode = 1'b0;

  always #5 clk = ~clk;

  softmax_ru_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .ru_in_0(ru_in_0), .ru_in_1(ru_in_1), .ru_sel_mult(ru_sel_mult),
    .ru_sel_mux(ru_sel_mux), .ru_out_0(ru_out_0), .ru_out_1(ru_out_1));

  // ---- behavioural RU (Mitchell log2/pow2, Q4.12) ----
  function automatic logic [15:0] f_log2(logic [15:0] x);
    int p;
    logic [15:0] nrm;
    logic [3:0] ip;
    if ($signed(x) <= 0) return 16'h8000;
    p = 0;
    for (int b = 0; b < 15; b++) if (x[b]) p = b;
    nrm = x << (14 - p);
    ip = 4'(p - 12);
    return {ip, nrm[13:2]};
  endfunction

  function automatic logic [15:0] f_diff(logic [15:0] a, logic [15:0] b, logic mult, logic mux);
    int d;
    d = int'($signed(b)) - (mux ? int'($signed(a)) : int'($signed(f_log2(a))));
    if (mult) d = (d * 5906) >>> 12;
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return d[15:0];
  endfunction

  function automatic logic [15:0] f_pow2(logic [15:0] x);
    int xi, i, m, r;
    xi = int'($signed(x));
    i = xi >>> 12;
    m = 4096 + (xi & 4095);
    if (i >= 0) r = m << i;
    else if (i < -13) r = 0;
    else r = m >>> (-i);
    if (r > 32767) r = 32767;
    return r[15:0];
  endfunction

  always_comb begin
    ru_out_0 = f_diff(ru_in_0, ru_in_1, ru_sel_mult, ru_sel_mux);
    ru_out_1 = f_pow2(ru_out_0);
  end

  // ---- vector-level softmax model ----
  function automatic logic [15:0] vmax(vec_t s);
    logic [15:0] m = 16'h8000;
    for (int k = 0; k < N; k++) if ($signed(s[k]) > $signed(m)) m = s[k];
    return m;
  endfunction
  function automatic logic [15:0] vexp(vec_t s, int k);
    return f_diff(vmax(s), s[k], 1'b1, 1'b1);
  endfunction
  function automatic logic [15:0] vsum(vec_t s);
    longint a = 0;
    for (int k = 0; k < N; k++) a += longint'(f_pow2(vexp(s, k)));
    return (a > 32767) ? 16'h7FFF : a[15:0];
  endfunction
  function automatic logic [15:0] vout(vec_t s, int k);
    return f_pow2(f_diff(vsum(s), vexp(s, k), 1'b0, 1'b0));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---- compare process: tracks the expected phase from observed handshakes ----
  int phase = 0, cnt = 0, cyc = 0, last_hs = 0;
  vec_t cur;
  logic [15:0] cur_max, cur_sum;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      phase = 0; cnt = 0;
    end else begin
      case (phase)
        0: begin
          chk("load_in_ready", in_ready, 1);
          chk("load_busy", busy, 0);
          chk("load_out_valid", out_valid, 0);
          chk("load_out_last", out_last, 0);
          chk("load_ru", {ru_in_0, ru_in_1, ru_sel_mult, ru_sel_mux}, 0);
          if (in_valid && in_ready) begin
            cur[cnt] = in_data;
            cnt++;
            if (cnt == N) begin
              cur_max = vmax(cur); cur_sum = vsum(cur);
              last_hs = cyc; phase = 1; cnt = 0;
            end
          end
        end
        1: begin
          chk("p1_busy", busy, 1);
          chk("p1_in_ready", in_ready, 0);
          chk("p1_out_valid", out_valid, 0);
          chk("p1_sel", {ru_sel_mult, ru_sel_mux}, 2'b11);
          chk("p1_ru_in_0_max", ru_in_0, cur_max);
          chk("p1_ru_in_1", ru_in_1, cur[cnt]);
          cnt++;
          if (cnt == N) begin phase = 2; cnt = 0; end
        end
        default: begin
          if (cnt == 0 && cyc == last_hs + N + 1) chk("latency", 1, 1);
          else if (cnt == 0 && cyc < last_hs + N + 2) chk("latency", cyc - last_hs, N + 1);
          chk("p2_busy", busy, 1);
          chk("p2_in_ready", in_ready, 0);
          chk("p2_out_valid", out_valid, 1);
          chk("p2_sel", {ru_sel_mult, ru_sel_mux}, 2'b00);
          chk("p2_ru_in_0_sum", ru_in_0, cur_sum);
          chk("p2_ru_in_1", ru_in_1, vexp(cur, cnt));
          chk("p2_out_data", out_data, vout(cur, cnt));
          chk("p2_out_last", out_last, (cnt == N - 1));
          if (out_ready) begin
            cnt++;
            if (cnt == N) begin phase = 0; cnt = 0; end
          end
        end
      endcase
    end
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(vec_t s, bit gaps, bit hold);
    bit ok;
    int guard;
    for (int k = 0; k < N; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin in_valid = 1'b0; @(posedge clk); #1; end
      in_valid = 1'b1; in_data = s[k];
      guard = 0;
      do begin
        @(negedge clk); ok = in_ready;
        @(posedge clk); #1; guard++;
      end while (!ok && guard < 1000);
      if (!ok) chk("send_timeout", 0, 1);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (phase != 0 && guard < 2000) begin @(negedge clk); guard++; end
    if (phase != 0) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = 16'($urandom);
    return v;
  endfunction

  vec_t v1, v2, v3, vr;
  initial begin
    for (int k = 0; k < N; k++) begin
      v1[k] = 16'h1000; v3[k] = 16'h8000;
      v2[k] = (k == 0) ? 16'h4000 : 16'hC000;
    end
    // hand-derived pins on the model
    chk("pin_v1_sum", vsum(v1), 16'h7FFF);
    chk("pin_v1_out", vout(v1, 0), 16'h0200);
    chk("pin_v2_max", vmax(v2), 16'h4000);
    chk("pin_v2_sum", vsum(v2), 16'h1070);
    chk("pin_v2_out0", vout(v2, 0), 16'h0FC8);
    chk("pin_v2_out1", vout(v2, 1), 16'h0010);
    chk("pin_v3_max", vmax(v3), 16'h8000);
    chk("pin_v3_exp", vexp(v3, 3), 16'h0000);
    chk("pin_v3_out", vout(v3, 7), 16'h0200);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    send(v1, 0, 0); wait_idle();
    send(v2, 1, 0); wait_idle();
    send(v3, 0, 0); wait_idle();

    rdy_mode = 1'b1;
    send(rnd_vec(), 1, 0); wait_idle();

    // reset in the middle of pass 1, then a fresh vector
    rdy_mode = 1'b0;
    send(v2, 0, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(v3, 0, 0); wait_idle();

    // back-to-back with in_valid held high across the passes
    send(v2, 0, 1);
    send(v1, 0, 0); wait_idle();

    rdy_mode = 1'b1;
    for (int t = 0; t < 6; t++) begin
      vr = rnd_vec();
      send(vr, 1, (t % 2) == 0);
    end
    wait_idle();
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
